syncfifo_prog: RTL
==================

Name: syncfifo_prog

Overview:
Single-clock FIFO, parametrised successor of the team's dual-clock FIFO. Adds run-time programmable almost-full/almost-empty thresholds, an occupancy count, synchronous clear and selectable standard/FWFT read mode. It serves as a generic same-domain buffer between pipeline stages and replaces ad-hoc register FIFOs.

Parameters:
DATA_WIDTH, 8, data bits per word, >=1
ADDR_WIDTH, 4, RAM address bits, >=1; DEPTH = 2**ADDR_WIDTH
RAM_STYLE, "distributed", RAM inference hint: "block" or "distributed"
FWFT_EN, 1'b1, 1 = first-word fall-through, 0 = standard read

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush, active high
din  in  DATA_WIDTH  write data
wr_en  in  1  write request
full  out  1  no write accepted this cycle
almost_full  out  1  data_count >= prog_full_th
prog_full_th  in  ADDR_WIDTH+1  almost-full threshold, quasi-static
rd_en  in  1  read request (pop in FWFT mode)
dout  out  DATA_WIDTH  read data
valid  out  1  dout holds a word read from the FIFO
empty  out  1  no read accepted this cycle
almost_empty  out  1  data_count <= prog_empty_th
prog_empty_th  in  ADDR_WIDTH+1  almost-empty threshold, quasi-static
data_count  out  ADDR_WIDTH+1  words held (RAM + FWFT output stage)

Behaviour:
- Reset (rst_n=0, async): pointers/count 0, dout 0, valid 0, empty 1, full 0, data_count 0; almost_empty 1; almost_full = (prog_full_th==0).
- Write accepted iff wr_en && !full, sampled pre-edge; stored at that edge.
- Standard mode (FWFT_EN=0): read accepted iff rd_en && !empty; dout updates after the same edge (1-cycle latency), valid high exactly that following cycle; dout holds last value otherwise. empty = (data_count==0), full = (data_count==DEPTH).
- FWFT mode: internal output register; head word moves RAM->dout on the edge after it is written (word written at edge N visible after edge N+1). valid = output register occupied; empty = !valid. Read accepted iff rd_en && valid; pop refills output register from RAM at the same edge if RAM non-empty, else valid falls. full = (RAM count==DEPTH); max data_count = DEPTH+1.
- Simultaneous accepted read+write: count unchanged, order preserved. At full: read accepted, write rejected. At empty: write accepted, read rejected (FWFT: word appears per fall-through latency).
- Pointers ADDR_WIDTH+1 bits, wrap naturally; full/empty from MSB compare.
- almost_full/almost_empty combinational from registered data_count and thresholds; threshold changes take effect immediately.
- clr: priority over wr_en/rd_en; after the edge state equals reset state (dout 0, valid 0); concurrent write discarded.
- Reset asserted mid-operation: immediate return to reset state, RAM contents irrelevant.

Optional Feature:
Macro SYNCFIFO_ERR_FLAG_EN. Defined: adds outputs overflow and underflow (1 bit each, reset 0); registered single-cycle pulse after an edge where wr_en && full (overflow) or rd_en && empty (underflow); clr forces both 0. Undefined: ports absent, rejected requests silently ignored; all other behaviour identical.

Test Plan:
1. FWFT_EN=0, DATA_WIDTH=8, ADDR_WIDTH=4: write 1..20 back-to-back, then rd_en 20 cycles -> full after 16th write, overflow pulses x4, reads return 1..16 one cycle after each rd_en with valid, underflow pulses x4, empty after 16th read.
2. FWFT_EN=1: single write 0xA5 into empty FIFO at edge N -> valid=1, dout=0xA5, data_count=1 after edge N+1; rd_en one cycle -> valid=0, empty=1, data_count=0.
3. Prefill 8, then wr_en=rd_en=1 for 10 cycles with 0x10..0x19 -> data_count stays 8, full/empty never assert, later reads return prefill then 0x10..0x19 in order.
4. prog_full_th=12, prog_empty_th=3: write 12 -> almost_full rises after 12th write edge; read 9 -> almost_empty rises when data_count reaches 3; set prog_full_th=0 -> almost_full=1 immediately.
5. count 7, assert clr with wr_en=1 din=0xFF -> next cycle data_count=0, empty=1, valid=0, dout=0; then write 0x3C, read -> 0x3C.
6. count 5 mid-burst, pulse rst_n low between edges -> outputs take reset values immediately, no overflow/underflow pulse; post-reset write/read of 0x5A succeeds.

Source files
------------

// File: rtl/syncfifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy
// count, synchronous clear and standard/FWFT read mode. SYNCFIFO_ERR_FLAG_EN adds overflow/underflow pulses.
module syncfifo_prog #(
   parameter int    DATA_WIDTH = 8,
   parameter int    ADDR_WIDTH = 4,
   parameter string RAM_STYLE  = "distributed",
   parameter bit    FWFT_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  wr_en,
   output logic                  full,
   output logic                  almost_full,
   input  logic [ADDR_WIDTH:0]   prog_full_th,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  valid,
   output logic                  empty,
   output logic                  almost_empty,
   input  logic [ADDR_WIDTH:0]   prog_empty_th,
   output logic [ADDR_WIDTH:0]   data_count
`ifdef SYNCFIFO_ERR_FLAG_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d, ram_rdata;
   logic                  valid_q, valid_d;
   logic                  ram_empty, ram_full, ram_rd;
   logic                  wr_acc, rd_acc;
   logic [ADDR_WIDTH:0]   ram_count;

   assign ram_empty = (wr_ptr_q == rd_ptr_q);
   assign ram_full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                      (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
   assign ram_count = wr_ptr_q - rd_ptr_q;

   assign full   = ram_full;
   assign empty  = FWFT_EN ? !valid_q : ram_empty;
   assign wr_acc = wr_en && !full && !clr;
   assign rd_acc = rd_en && !empty && !clr;
   // FWFT pulls the RAM head whenever the output stage is free or being popped this edge.
   assign ram_rd = FWFT_EN ? (!ram_empty && (!valid_q || rd_acc) && !clr) : rd_acc;

   assign data_count   = ram_count + (ADDR_WIDTH+1)'(FWFT_EN && valid_q);
   assign almost_full  = (data_count >= prog_full_th);
   assign almost_empty = (data_count <= prog_empty_th);
   assign dout         = dout_q;
   assign valid        = valid_q;

   generate
      if (RAM_STYLE == "block") begin : g_block_ram
         (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
         // NOTE: storage has no reset; the pointers alone decide which words are live.
         always_ff @(posedge clk) begin
            if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
         end
         assign ram_rdata = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end else begin : g_dist_ram
         (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
         always_ff @(posedge clk) begin
            if (wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
         end
         assign ram_rdata = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
   endgenerate

   always_comb begin
      // NOTE: every next-state value gets a default first so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
      valid_d  = valid_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         dout_d   = '0;
         valid_d  = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
         if (ram_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = ram_rdata;
         end
         valid_d = FWFT_EN ? (ram_rd || (valid_q && !rd_acc)) : ram_rd;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
      end
   end

`ifdef SYNCFIFO_ERR_FLAG_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= wr_en && full && !clr;
         underflow_q <= rd_en && empty && !clr;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule
